// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC time/date poller: FSM states,
// register offsets within the seven-byte time block, and per-register masks.
package rtc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    PUB   = 3'd4
  } state_t;

  localparam int unsigned NUM_REGS = 7;

  localparam logic [2:0] OFS_SEC     = 3'd0;
  localparam logic [2:0] OFS_MIN     = 3'd1;
  localparam logic [2:0] OFS_HOUR    = 3'd2;
  localparam logic [2:0] OFS_DAY     = 3'd3;
  localparam logic [2:0] OFS_WEEKDAY = 3'd4;
  localparam logic [2:0] OFS_MONTH   = 3'd5;
  localparam logic [2:0] OFS_YEAR    = 3'd6;

  localparam logic [7:0] MASK_SEC     = 8'h7F;
  localparam logic [7:0] MASK_MIN     = 8'h7F;
  localparam logic [7:0] MASK_HOUR    = 8'h3F;
  localparam logic [7:0] MASK_DAY     = 8'h3F;
  localparam logic [7:0] MASK_WEEKDAY = 8'h07;
  localparam logic [7:0] MASK_MONTH   = 8'h1F;
  localparam logic [7:0] MASK_YEAR    = 8'hFF;

  function automatic logic [7:0] reg_mask(input logic [2:0] ofs);
    logic [7:0] m;
    m = MASK_YEAR;
    case (ofs)
      OFS_SEC:     m = MASK_SEC;
      OFS_MIN:     m = MASK_MIN;
      OFS_HOUR:    m = MASK_HOUR;
      OFS_DAY:     m = MASK_DAY;
      OFS_WEEKDAY: m = MASK_WEEKDAY;
      OFS_MONTH:   m = MASK_MONTH;
      default:     m = MASK_YEAR;
    endcase
    return m;
  endfunction

  // Valid BCD compares correctly as plain hex, so bounds are given in BCD.
  function automatic logic bcd_in_range(input logic [7:0] v,
                                        input logic [7:0] lo,
                                        input logic [7:0] hi);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/rtc_poll_timer.sv
// Free-running poll period counter; tick is high for the single cycle in
// which the counter sits at its terminal value POLL_CYC-1.
module rtc_poll_timer #(
  parameter int unsigned POLL_CYC = 12_500_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(POLL_CYC - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tick = (cnt_reg == CNT_LAST);

endmodule

// File: rtl/rtc_time_poll.sv
// Periodically reads the seven RTC time/date registers byte by byte and
// publishes them when the seconds change. Optional range check: RTC_BCD_CHECK_EN.
module rtc_time_poll
  import rtc_pkg::*;
#(
  parameter int unsigned POLL_CYC    = 12_500_000,
  parameter logic [7:0]  BASE_ADDR   = 8'h02,
  parameter int unsigned TIMEOUT_CYC = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rd_req,
  output logic [7:0]  rd_addr,
  input  logic        rd_done,
  input  logic [7:0]  rd_data,
  input  logic        rd_err,
  output logic [23:0] time_data,
  output logic [31:0] date_data,
  output logic        date_time_en,
  output logic        busy
);

  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [2:0] IDX_LAST = 3'(NUM_REGS - 1);

  state_t        state_reg, state_next;
  logic [2:0]    idx_reg;
  logic [TW-1:0] to_cnt_reg;
  logic [7:0]    cap_reg [NUM_REGS];
  logic          published_reg;
  logic [23:0]   time_data_reg;
  logic [31:0]   date_data_reg;
  logic          date_time_en_reg;
  logic          tick;
  logic          byte_done;
  logic          sec_changed;
  logic          range_ok;

  rtc_poll_timer #(
    .POLL_CYC (POLL_CYC)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Completion strobes only count while waiting on the bus.
  assign byte_done   = (state_reg == WAIT) && rd_done;
  assign sec_changed = !published_reg || (cap_reg[OFS_SEC] != time_data_reg[7:0]);

`ifdef RTC_BCD_CHECK_EN
  assign range_ok = bcd_in_range(cap_reg[OFS_SEC],     8'h00, 8'h59) &&
                    bcd_in_range(cap_reg[OFS_MIN],     8'h00, 8'h59) &&
                    bcd_in_range(cap_reg[OFS_HOUR],    8'h00, 8'h23) &&
                    bcd_in_range(cap_reg[OFS_DAY],     8'h01, 8'h31) &&
                    bcd_in_range(cap_reg[OFS_WEEKDAY], 8'h00, 8'h06) &&
                    bcd_in_range(cap_reg[OFS_MONTH],   8'h01, 8'h12) &&
                    bcd_in_range(cap_reg[OFS_YEAR],    8'h00, 8'h99);
`else
  assign range_ok = 1'b1;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (tick) state_next = REQ;
      REQ:   state_next = WAIT;
      WAIT: begin
        if (rd_done) begin
          state_next = (idx_reg == IDX_LAST) ? CHECK : REQ;
        end else if (rd_err || (to_cnt_reg == TO_LAST)) begin
          state_next = IDLE;
        end
      end
      CHECK: state_next = (sec_changed && range_ok) ? PUB : IDLE;
      PUB:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      idx_reg    <= 3'd0;
      to_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE) begin
        idx_reg <= 3'd0;
      end else if (byte_done && (idx_reg != IDX_LAST)) begin
        idx_reg <= idx_reg + 3'd1;
      end
      if (state_reg == REQ) begin
        to_cnt_reg <= '0;
      end else if (state_reg == WAIT) begin
        to_cnt_reg <= to_cnt_reg + 1'b1;
      end
    end
  end

  // One capture register per RTC byte, masked on the way in.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cap
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cap_reg[gi] <= 8'h00;
        end else if (byte_done && (idx_reg == 3'(gi))) begin
          cap_reg[gi] <= rd_data & reg_mask(3'(gi));
        end
      end
    end
  endgenerate

  // Outputs load on the edge entering PUB so data and strobe appear together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_data_reg    <= 24'h0;
      date_data_reg    <= 32'h0;
      date_time_en_reg <= 1'b0;
      published_reg    <= 1'b0;
    end else begin
      date_time_en_reg <= (state_next == PUB);
      if (state_next == PUB) begin
        time_data_reg <= {cap_reg[OFS_HOUR], cap_reg[OFS_MIN], cap_reg[OFS_SEC]};
        date_data_reg <= {cap_reg[OFS_YEAR], cap_reg[OFS_MONTH],
                          cap_reg[OFS_DAY], cap_reg[OFS_WEEKDAY]};
        published_reg <= 1'b1;
      end
    end
  end

  assign rd_req       = (state_reg == REQ) || (state_reg == WAIT);
  assign rd_addr      = BASE_ADDR + {5'd0, idx_reg};
  assign busy         = (state_reg != IDLE);
  assign time_data    = time_data_reg;
  assign date_data    = date_data_reg;
  assign date_time_en = date_time_en_reg;

endmodule

// File: tb/tb_rtc_time_poll.sv
// Directed bench for rtc_time_poll: a hand-driven I2C read model answers each
// byte request; expected outputs are hand-computed constants.
module tb_rtc_time_poll;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req;
  logic [7:0]  rd_addr;
  logic        rd_done;
  logic [7:0]  rd_data;
  logic        rd_err;
  logic [23:0] time_data;
  logic [31:0] date_data;
  logic        date_time_en;
  logic        busy;

  int total = 0;
  int bad   = 0;

  rtc_time_poll #(
    .POLL_CYC    (100),
    .BASE_ADDR   (8'h02),
    .TIMEOUT_CYC (50)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_done      (rd_done),
    .rd_data      (rd_data),
    .rd_err       (rd_err),
    .time_data    (time_data),
    .date_data    (date_data),
    .date_time_en (date_time_en),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a request, checks its address, then answers it.
  task automatic serve(input string tag, input logic [7:0] val,
                       input logic [7:0] addr, input bit err);
    int n;
    n = 0;
    while (!rd_req && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req_seen"}, {31'd0, rd_req}, 32'd1);
    chk({tag, "_addr"}, {24'd0, rd_addr}, {24'd0, addr});
    @(negedge clk);
    @(negedge clk);
    rd_data = val;
    if (err) rd_err = 1'b1;
    else     rd_done = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
    rd_err  = 1'b0;
    rd_data = 8'h00;
  endtask

  // Serves all seven bytes, then checks the 2-cycle publish latency.
  task automatic run_frame(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4,
                           input logic [7:0] b5, input logic [7:0] b6, input bit exp_pub,
                           input logic [23:0] exp_time, input logic [31:0] exp_date);
    logic [7:0] b [7];
    b = '{b0, b1, b2, b3, b4, b5, b6};
    for (int i = 0; i < 7; i++) serve(tag, b[i], 8'h02 + 8'(i), 1'b0);
    chk({tag, "_en_lat1"}, {31'd0, date_time_en}, 32'd0);
    chk({tag, "_req_fall"}, {31'd0, rd_req}, 32'd0);
    @(negedge clk);
    chk({tag, "_en_lat2"}, {31'd0, date_time_en}, {31'd0, exp_pub});
    chk({tag, "_time"}, {8'd0, time_data}, {8'd0, exp_time});
    chk({tag, "_date"}, date_data, exp_date);
    @(negedge clk);
    chk({tag, "_en_once"}, {31'd0, date_time_en}, 32'd0);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    $display("frame %s sec=%h pub=%0d time=%h date=%h", tag, b0, exp_pub, time_data, date_data);
  endtask

  initial begin
    int   n;
    bit   en_seen;
    rst     = 1'b1;
    rd_done = 1'b0;
    rd_err  = 1'b0;
    rd_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_time", {8'd0, time_data}, 32'd0);
    chk("rst_date", date_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_req", {31'd0, rd_req}, 32'd0);
    chk("rst_addr", {24'd0, rd_addr}, 32'h02);
    rst = 1'b0;

    // Stray completion while idle is ignored.
    @(negedge clk);
    rd_done = 1'b1; rd_data = 8'h11;
    @(negedge clk);
    rd_done = 1'b0;
    chk("stray_busy", {31'd0, busy}, 32'd0);
    chk("stray_en", {31'd0, date_time_en}, 32'd0);

    run_frame("basic", 8'h45, 8'h30, 8'h12, 8'h15, 8'h03, 8'h06, 8'h24,
              1'b1, 24'h123045, 32'h24061503);
    // Same seconds: no publish.
    run_frame("dup", 8'h45, 8'h31, 8'h13, 8'h16, 8'h04, 8'h07, 8'h25,
              1'b0, 24'h123045, 32'h24061503);
    // Masking: high bits stripped before publish.
    run_frame("mask", 8'hC6, 8'hB1, 8'hD3, 8'hD6, 8'hFC, 8'hE7, 8'h25,
              1'b1, 24'h133146, 32'h25071604);

    // Bus error on byte 3 aborts quietly.
    serve("err", 8'h50, 8'h02, 1'b0);
    serve("err", 8'h31, 8'h03, 1'b0);
    serve("err", 8'h13, 8'h04, 1'b0);
    serve("err", 8'h16, 8'h05, 1'b1);
    chk("err_busy", {31'd0, busy}, 32'd0);
    chk("err_en", {31'd0, date_time_en}, 32'd0);
    chk("err_time", {8'd0, time_data}, 32'h133146);
    $display("frame err aborted time=%h", time_data);

    run_frame("after_err", 8'h50, 8'h31, 8'h13, 8'h16, 8'h04, 8'h07, 8'h25,
              1'b1, 24'h133150, 32'h25071604);

`ifdef RTC_BCD_CHECK_EN
    run_frame("bad_bcd", 8'h5A, 8'h31, 8'h13, 8'h16, 8'h04, 8'h07, 8'h25,
              1'b0, 24'h133150, 32'h25071604);
`else
    run_frame("bad_bcd", 8'h5A, 8'h31, 8'h13, 8'h16, 8'h04, 8'h07, 8'h25,
              1'b1, 24'h13315A, 32'h25071604);
`endif

    // Never answer byte 0: REQ (1) + WAIT (50) cycles with rd_req high.
    n = 0;
    while (!rd_req && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("to_req_seen", {31'd0, rd_req}, 32'd1);
    n = 0;
    en_seen = 1'b0;
    while (rd_req && n < 200) begin
      if (date_time_en) en_seen = 1'b1;
      n++;
      @(negedge clk);
    end
    chk("to_cycles", n, 32'd51);
    chk("to_busy", {31'd0, busy}, 32'd0);
    chk("to_en", {31'd0, en_seen}, 32'd0);
    $display("frame timeout req_cycles=%0d", n);

    // Reset in the middle of byte 4.
    for (int i = 0; i < 4; i++) serve("mid", 8'h10, 8'h02 + 8'(i), 1'b0);
    n = 0;
    while (!rd_req && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("mid_addr4", {24'd0, rd_addr}, 32'h06);
    rst = 1'b1;
    #1;
    chk("mid_rst_time", {8'd0, time_data}, 32'd0);
    chk("mid_rst_date", date_data, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_req", {31'd0, rd_req}, 32'd0);
    chk("mid_rst_addr", {24'd0, rd_addr}, 32'h02);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    $display("frame reset mid-byte-4 time=%h date=%h", time_data, date_data);
    // Published flag cleared: sec=00 still publishes despite matching time_data.
    run_frame("post_rst", 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00,
              1'b1, 24'h000000, 32'h00010100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rtc_time_poll.md
RTC_TIME_POLL -- requirements
Module: rtc_time_poll

Interface
REQ-001 SHALL have parameter POLL_CYC, default 12_500_000: clk cycles between poll starts (4 Hz at 50 MHz).
REQ-002 SHALL have parameter BASE_ADDR, default 8'h02: RTC register address of seconds; the 7 registers sec, min, hour, day, weekday, month, year sit at BASE_ADDR+0..+6.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 100_000: maximum wait for rd_done per byte.
REQ-004 SHALL have port clk, input, 1: sole clock, all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port rd_req, output, 1: byte-read request to the I2C controller.
REQ-007 SHALL have port rd_addr, output, 8: register address for the current request.
REQ-008 SHALL have port rd_done, input, 1: one-cycle pulse, read complete; rd_data valid in the same cycle.
REQ-009 SHALL have port rd_data, input, 8: byte read from the RTC.
REQ-010 SHALL have port rd_err, input, 1: one-cycle pulse, I2C NACK or bus error; replaces rd_done.
REQ-011 SHALL have port time_data, output, 24: {hour, min, sec}, BCD.
REQ-012 SHALL have port date_data, output, 32: {year, month, day, weekday}, BCD.
REQ-013 SHALL have port date_time_en, output, 1: one-cycle pulse, new time/date published.
REQ-014 SHALL have port busy, output, 1: high while a frame read is in progress.

Function
REQ-015 States SHALL be IDLE, REQ, WAIT, CHECK, PUB.
- IDLE -> REQ on poll tick.
- REQ -> WAIT after one cycle.
- WAIT -> REQ (next byte) or CHECK (after byte 6).
- CHECK -> PUB or IDLE.
- PUB -> IDLE.
REQ-016 Poll counter SHALL count 0..POLL_CYC-1 continuously. The tick at the wrap SHALL be accepted only in IDLE; a tick arriving while busy SHALL be dropped, not queued.
REQ-017 In REQ and WAIT, rd_req SHALL be high and rd_addr SHALL equal BASE_ADDR+idx (idx 0..6). rd_req SHALL fall in the cycle after rd_done or rd_err is sampled.
REQ-018 On rd_done, rd_data SHALL be stored, masked as follows: sec&7F, min&7F, hour&3F, day&3F, weekday&07, month&1F, year&FF.
REQ-019 rd_err, or TIMEOUT_CYC cycles in WAIT without rd_done, SHALL abort the frame to IDLE. The abort SHALL leave outputs unchanged and produce no date_time_en.
REQ-020 rd_done or rd_err received outside WAIT SHALL be ignored.
REQ-021 In CHECK, the frame SHALL proceed to PUB if the captured seconds differ from the last published seconds, or if no frame has been published since reset; otherwise it SHALL return to IDLE.
REQ-022 In PUB, time_data and date_data SHALL update and date_time_en SHALL pulse high for exactly one cycle, in the same cycle. Latency SHALL be 2 clk cycles from the final rd_done to date_time_en.
REQ-023 busy SHALL be high in REQ, WAIT, CHECK and PUB.
REQ-024 rd_addr arithmetic SHALL be 8-bit and wrap modulo 256 (BASE_ADDR=8'hFE reads FE, FF, 00, ...).

Reset
REQ-025 Asserting rst SHALL, asynchronously: set rd_req=0, rd_addr=BASE_ADDR, time_data=0, date_data=0, date_time_en=0, busy=0, state=IDLE, poll counter=0, and clear the published-once flag.
REQ-026 rst asserted mid-frame SHALL discard the partial frame; the first tick after release SHALL start a full frame from idx 0.

Configuration
REQ-027 With RTC_BCD_CHECK_EN defined, CHECK SHALL reject the frame to IDLE (no publish) if any nibble exceeds 9, or if sec>59, min>59, hour>23, day not in 1..31, month not in 1..12, or weekday>6.
REQ-028 Without RTC_BCD_CHECK_EN, no range check SHALL be performed and masked values SHALL publish as-is.

Structure
REQ-029 Package rtc_pkg SHALL hold the state enum, register offset constants (OFS_SEC..OFS_YEAR), and per-register masks.
REQ-030 Sub-module rtc_poll_timer SHALL hold the POLL_CYC counter and generate the tick; the FSM, capture and check logic SHALL live in the top module.

Verification
REQ-031 POLL_CYC=100; model returns 45,30,12,15,03,06,24 -> time_data=24'h123045, date_data=32'h24061503, one date_time_en pulse.
REQ-032 Two polls returning identical sec=45 -> only the first poll pulses date_time_en; second poll returns to IDLE.
REQ-033 rd_err on byte 3 -> no pulse, outputs unchanged; next poll succeeds normally.
REQ-034 Model never answers byte 0, TIMEOUT_CYC=50 -> abort after 50 cycles, busy falls, no pulse.
REQ-035 RTC_BCD_CHECK_EN defined, sec byte 8'h5A -> frame rejected; undefined -> published with sec=5A.
REQ-036 rst pulsed during byte 4 -> all outputs zero; next frame restarts at rd_addr=BASE_ADDR.
